// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA frame-buffer arbiter.
// Frame geometry constants, derived-size helpers and the RAM slot-owner tag.
package vga_fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_VGA    = 2'd1,
    SLOT_CPU_RD = 2'd2,
    SLOT_CPU_WR = 2'd3
  } slot_owner_e;

  function automatic int calc_ppw(input int word_w, input int bpp);
    return word_w / bpp;
  endfunction

  function automatic int calc_frame_words(input int word_w, input int bpp);
    return (H_ACTIVE * V_ACTIVE) / calc_ppw(word_w, bpp);
  endfunction

endpackage

// File: rtl/vga_fb_prefetch_fifo.sv
// Small synchronous word FIFO for the VGA prefetch path.
// Flush has priority over push and pop; count_o reports stored words.
module vga_fb_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        wr_d = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_i) begin
        rd_d = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port video RAM arbiter: VGA prefetch (priority) vs CPU req/ack, plus pixel unpacker.
// Optional FB_DOUBLE_BUFFER_EN adds bufSel to select the frame base at frameStart.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int WORD_W      = 16,
  parameter int BPP         = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = calc_frame_words(WORD_W, BPP)
) (
  input  logic              clock25Mhz,
  input  logic              resetN,
  input  logic              frameStart,
  input  logic              isActive,
`ifdef FB_DOUBLE_BUFFER_EN
  input  logic              bufSel,
`endif
  output logic [BPP-1:0]    pixelOut,
  output logic              underflow,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [WORD_W-1:0] cpuWdata,
  output logic              cpuAck,
  output logic [WORD_W-1:0] cpuRdata,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [WORD_W-1:0] memWdata,
  input  logic [WORD_W-1:0] memRdata
);

  localparam int PPW   = calc_ppw(WORD_W, BPP);
  localparam int SUB_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_WORDS);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PPW - 1);

  slot_owner_e       own_q, own_d, pend_q;
  logic              stale_q, stale_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d, base_q, base_d;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, rdata_q;
  logic [BPP-1:0]    pix_q, pix_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              und_q, und_d;

  logic              push_s, pop_s, fifo_empty_s, vga_want_s, cpu_busy_s;
  logic [WORD_W-1:0] fifo_head_s;
  logic [CW-1:0]     fifo_count_s;
  logic [CW:0]       occ_s;

  vga_fb_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk_i   (clock25Mhz),
    .rst_n_i (resetN),
    .push_i  (push_s),
    .data_i  (memRdata),
    .pop_i   (pop_s),
    .flush_i (frameStart),
    .head_o  (fifo_head_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s)
  );

  // A stale (pre-frameStart) VGA read no longer occupies a FIFO slot.
  assign occ_s = {1'b0, fifo_count_s}
               + (CW+1)'(own_q == SLOT_VGA)
               + (CW+1)'((pend_q == SLOT_VGA) && !stale_q);
  assign vga_want_s = !frameStart && (fetch_q < FRAME_LIM) && (occ_s < (CW+1)'(FIFO_DEPTH));
  assign cpu_busy_s = (own_q == SLOT_CPU_RD) || (own_q == SLOT_CPU_WR) ||
                      (pend_q == SLOT_CPU_RD) || (pend_q == SLOT_CPU_WR);
  assign push_s     = (pend_q == SLOT_VGA) && !stale_q && !frameStart;

  assign cpuAck   = (pend_q == SLOT_CPU_RD) || (pend_q == SLOT_CPU_WR);
  assign cpuRdata = (pend_q == SLOT_CPU_RD) ? memRdata : rdata_q;

  // Issue-slot arbitration and frame base selection.
  always_comb begin
    own_d   = SLOT_IDLE;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    fetch_d = frameStart ? '0 : fetch_q;
    stale_d = frameStart && (own_q == SLOT_VGA);
`ifdef FB_DOUBLE_BUFFER_EN
    base_d  = frameStart ? (bufSel ? FRAME_LIM : '0) : base_q;
`else
    base_d  = '0;
`endif
    if (vga_want_s) begin
      own_d   = SLOT_VGA;
      en_d    = 1'b1;
      addr_d  = fetch_q + base_q;
      fetch_d = fetch_q + ADDR_W'(1);
    end else if (cpuReq && !cpu_busy_s) begin
      own_d   = cpuWe ? SLOT_CPU_WR : SLOT_CPU_RD;
      en_d    = 1'b1;
      we_d    = cpuWe;
      addr_d  = cpuAddr;
      wdata_d = cpuWdata;
    end else begin
      own_d   = SLOT_IDLE;
    end
  end

  // Pixel unpacker: lowest bits first, pop on the last pixel of a word.
  always_comb begin
    pix_d = '0;
    sub_d = sub_q;
    und_d = und_q;
    pop_s = 1'b0;
    if (frameStart) begin
      sub_d = '0;
      und_d = 1'b0;
    end else if (isActive) begin
      if (!fifo_empty_s) begin
        pix_d = fifo_head_s[int'(sub_q)*BPP +: BPP];
        pop_s = (sub_q == SUB_LAST);
      end else begin
        und_d = 1'b1;
      end
      sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
    end else begin
      sub_d = sub_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock25Mhz or negedge resetN) begin
    if (!resetN) begin
      own_q   <= SLOT_IDLE;
      pend_q  <= SLOT_IDLE;
      stale_q <= 1'b0;
      fetch_q <= '0;
      base_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      pix_q   <= '0;
      sub_q   <= '0;
      und_q   <= 1'b0;
    end else begin
      own_q   <= own_d;
      pend_q  <= own_q;
      stale_q <= stale_d;
      fetch_q <= fetch_d;
      base_q  <= base_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= cpuRdata;
      pix_q   <= pix_d;
      sub_q   <= sub_d;
      und_q   <= und_d;
    end
  end

  assign memEn     = en_q;
  assign memWe     = we_q;
  assign memAddr   = addr_q;
  assign memWdata  = wdata_q;
  assign pixelOut  = pix_q;
  assign underflow = und_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: pixel table with scoreboard plus
// hand-written CPU, underflow, reset and (FB_DOUBLE_BUFFER_EN) double-buffer sequences.
module tb_vga_fb_arbiter;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int AW = 18;
`else
  localparam int AW = 17;
`endif

  logic          clock25Mhz = 1'b0;
  logic          resetN = 1'b0, frameStart = 1'b0, isActive = 1'b0;
  logic          bufSel = 1'b0;
  logic [3:0]    pixelOut;
  logic          underflow, cpuAck, memEn, memWe;
  logic          cpuReq = 1'b0, cpuWe = 1'b0;
  logic [AW-1:0] cpuAddr = '0, memAddr;
  logic [15:0]   cpuWdata = '0, cpuRdata, memWdata, memRdata = '0;
  bit            ram_mode = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct { logic act; logic [3:0] exp; } pix_vec_t;
  pix_vec_t   tbl [19];
  logic [3:0] sb_q [$];

  vga_fb_arbiter #(.ADDR_W(AW)) dut (
    .clock25Mhz (clock25Mhz),
    .resetN     (resetN),
    .frameStart (frameStart),
    .isActive   (isActive),
`ifdef FB_DOUBLE_BUFFER_EN
    .bufSel     (bufSel),
`endif
    .pixelOut   (pixelOut),
    .underflow  (underflow),
    .cpuReq     (cpuReq),
    .cpuWe      (cpuWe),
    .cpuAddr    (cpuAddr),
    .cpuWdata   (cpuWdata),
    .cpuAck     (cpuAck),
    .cpuRdata   (cpuRdata),
    .memEn      (memEn),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memRdata   (memRdata)
  );

  always #20 clock25Mhz = ~clock25Mhz;

  function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
    return ram_mode ? (16'h4321 ^ a[15:0]) : 16'h4321;
  endfunction

  always @(posedge clock25Mhz) begin
    if (memEn && !memWe) memRdata <= ram_word(memAddr);
  end

  initial begin
    #(40 * 5000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock25Mhz);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pix_step(input logic act, input logic [3:0] exp);
    isActive = act;
    sb_q.push_back(exp);
    tick();
    check("pixel", 32'(pixelOut), 32'(sb_q.pop_front()));
  endtask

  task automatic wait_mem(input string nm, input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(memEn === 1'b1 && memAddr === a) && n < budget) begin
      tick();
      n++;
    end
    check(nm, 32'(memAddr), 32'(a));
    check({nm, "_en"}, 32'(memEn), 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_pix"}, 32'(pixelOut), 32'd0);
    check({nm, "_und"}, 32'(underflow), 32'd0);
    check({nm, "_ack"}, 32'(cpuAck), 32'd0);
    check({nm, "_rdata"}, 32'(cpuRdata), 32'd0);
    check({nm, "_en"}, 32'(memEn), 32'd0);
    check({nm, "_we"}, 32'(memWe), 32'd0);
    check({nm, "_addr"}, 32'(memAddr), 32'd0);
    check({nm, "_wdata"}, 32'(memWdata), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd1}; tbl[1]  = '{1'b1, 4'd2}; tbl[2]  = '{1'b1, 4'd3};
    tbl[3]  = '{1'b1, 4'd4}; tbl[4]  = '{1'b1, 4'd1}; tbl[5]  = '{1'b0, 4'd0};
    tbl[6]  = '{1'b1, 4'd2}; tbl[7]  = '{1'b1, 4'd3}; tbl[8]  = '{1'b0, 4'd0};
    tbl[9]  = '{1'b0, 4'd0}; tbl[10] = '{1'b1, 4'd4}; tbl[11] = '{1'b1, 4'd1};
    tbl[12] = '{1'b1, 4'd2}; tbl[13] = '{1'b1, 4'd3}; tbl[14] = '{1'b1, 4'd4};
    tbl[15] = '{1'b1, 4'd1}; tbl[16] = '{1'b1, 4'd2}; tbl[17] = '{1'b1, 4'd3};
    tbl[18] = '{1'b1, 4'd4};

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    resetN = 1'b1;
    repeat (10) tick();

    // frameStart: four back-to-back fetches 0..3, then stall
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    wait_mem("fetch0", '0, 5);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("fetch_seq_en", 32'(memEn), 32'd1);
      check("fetch_seq_addr", 32'(memAddr), 32'(i));
    end
    tick();
    check("fetch_stall", 32'(memEn), 32'd0);
    tick();
    check("fetch_stall2", 32'(memEn), 32'd0);

    // Pixel stream table
    for (int i = 0; i < 19; i++) pix_step(tbl[i].act, tbl[i].exp);
    isActive = 1'b0;
    check("no_underflow", 32'(underflow), 32'd0);
    repeat (6) tick();

    // CPU write while FIFO full, then back-to-back request
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = AW'(17'h00100); cpuWdata = 16'hBEEF;
    wait_mem("wr_addr", AW'(17'h00100), 5);
    check("wr_we", 32'(memWe), 32'd1);
    check("wr_wdata", 32'(memWdata), 32'hBEEF);
    check("wr_ack_early", 32'(cpuAck), 32'd0);
    tick();
    check("wr_ack", 32'(cpuAck), 32'd1);
    check("wr_rdata_hold", 32'(cpuRdata), 32'd0);
    check("wr_no_regrant1", 32'(memEn), 32'd0);
    cpuAddr = AW'(17'h00101); cpuWdata = 16'hCAFE;
    tick();
    check("wr_ack_pulse", 32'(cpuAck), 32'd0);
    check("wr_no_regrant2", 32'(memEn), 32'd0);
    wait_mem("wr2_addr", AW'(17'h00101), 5);
    check("wr2_wdata", 32'(memWdata), 32'hCAFE);
    tick();
    check("wr2_ack", 32'(cpuAck), 32'd1);
    cpuReq = 1'b0; cpuWe = 1'b0;
    tick();
    check("wr2_ack_pulse", 32'(cpuAck), 32'd0);
    repeat (4) tick();

    // CPU read contending with a freshly freed FIFO slot
    ram_mode = 1'b1;
    isActive = 1'b1;
    repeat (4) tick();
    isActive = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = AW'(17'h00234);
    tick();
    check("rd_vga_first_en", 32'(memEn), 32'd1);
    check("rd_vga_first", 32'(memAddr == AW'(17'h00234)), 32'd0);
    check("rd_vga_first_ack", 32'(cpuAck), 32'd0);
    tick();
    check("rd_grant_en", 32'(memEn), 32'd1);
    check("rd_grant_we", 32'(memWe), 32'd0);
    check("rd_grant_addr", 32'(memAddr), 32'h234);
    tick();
    check("rd_ack", 32'(cpuAck), 32'd1);
    check("rd_data", 32'(cpuRdata), 32'(16'h4321 ^ 16'h0234));
    cpuReq = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(cpuAck), 32'd0);
    check("rd_data_hold", 32'(cpuRdata), 32'(16'h4321 ^ 16'h0234));
    repeat (4) tick();

    // Underflow right after frameStart, sticky, cleared by next frameStart
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    isActive = 1'b1;
    tick();
    check("underflow_set", 32'(underflow), 32'd1);
    check("underflow_pix", 32'(pixelOut), 32'd0);
    isActive = 1'b0;
    repeat (6) tick();
    check("underflow_sticky", 32'(underflow), 32'd1);
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    check("underflow_clear", 32'(underflow), 32'd0);
    repeat (8) tick();
    for (int i = 0; i < 4; i++) pix_step(1'b1, 4'(i + 1));
    isActive = 1'b0;
    check("underflow_stays_clear", 32'(underflow), 32'd0);
    repeat (4) tick();

    // Reset in the middle of a CPU read
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = AW'(17'h00055);
    wait_mem("rst_rd_grant", AW'(17'h00055), 10);
    resetN = 1'b0;
    #1;
    check_all_zero("rst_mid");
    cpuReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_ack", 32'(cpuAck), 32'd0);
    end
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_ack", 32'(cpuAck), 32'd0);
    end
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = AW'(17'h00066);
    begin
      int n = 0;
      while (cpuAck !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    check("post_rst_ack", 32'(cpuAck), 32'd1);
    check("post_rst_rdata", 32'(cpuRdata), 32'(16'h4321 ^ 16'h0066));
    cpuReq = 1'b0;
    repeat (6) tick();

`ifdef FB_DOUBLE_BUFFER_EN
    // Back-buffer selection sampled only at frameStart
    bufSel = 1'b1;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    wait_mem("db_first", AW'(76800), 6);
    bufSel = 1'b0;
    repeat (8) tick();
    isActive = 1'b1;
    repeat (4) tick();
    isActive = 1'b0;
    wait_mem("db_hold_base", AW'(76804), 6);
    repeat (4) tick();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    wait_mem("db_front", '0, 6);
    repeat (4) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
